// File: rtl/instruction_buffer_pkg.sv
// Shared core definitions for fetch/decode and the instruction buffer:
// entry layout, lane count and opcode constants.
`timescale 1ns/1ps
package instruction_buffer_pkg;

    localparam int IB_LANES  = 4;
    localparam int ENTRY_W   = 42;
    localparam int OPCODE_W  = 4;
    localparam int IMM_W     = 8;
    localparam int REG_W     = 4;
    localparam int OWNER_W   = 4;
    localparam int FIELDS_W  = OPCODE_W + IMM_W + 3*REG_W + 2*(1 + OWNER_W) + 4;
    localparam int RSVD_W    = ENTRY_W - FIELDS_W;

    // Decoded fields sit MSB-first from the top of the entry; spare bits pad the bottom.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [IMM_W-1:0]    imm;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    ra;
        logic [REG_W-1:0]    rb;
        logic                a_dep;
        logic [OWNER_W-1:0]  a_owner;
        logic                b_dep;
        logic [OWNER_W-1:0]  b_owner;
        logic                uses_rb;
        logic                is_ld_str;
        logic                is_fxu;
        logic                is_branch;
        logic [RSVD_W-1:0]   rsvd;
    } ib_entry_t;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_LD  = 4'd5,
        OP_ST  = 4'd6,
        OP_BR  = 4'd7
    } opcode_e;

    function automatic logic [OPCODE_W-1:0] entry_opcode(input logic [ENTRY_W-1:0] e);
        ib_entry_t t;
        t = ib_entry_t'(e);
        return t.opcode;
    endfunction

endpackage

// File: rtl/ib_count_clip.sv
// Unsigned min(request, limit); shared by the enqueue and dequeue clipping.
`timescale 1ns/1ps
module ib_count_clip #(
    parameter int W = 3
) (
    input  logic [W-1:0] i_req,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_min
);

    assign o_min = (i_req < i_limit) ? i_req : i_limit;

endmodule

// File: rtl/instruction_buffer.sv
// Circular instruction buffer between decode and dispatch: up to four
// entries in and four out per cycle, oldest entry presented on lane 0.
`timescale 1ns/1ps
module instruction_buffer
    import instruction_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LANES = IB_LANES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(LANES+1)-1:0]  enq_count,
    input  logic [LANES*ENTRY_W-1:0]    enq_entry_flat,
    output logic [$clog2(LANES+1)-1:0]  num_fetch,
    output logic [LANES*ENTRY_W-1:0]    deq_entry_flat,
    output logic [LANES-1:0]            deq_valid_flat,
    input  logic [$clog2(LANES+1)-1:0]  deq_count,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      count_out,
    output logic                        enq_drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(LANES + 1);

    ib_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_drop_err;

    logic [CW-1:0]     w_free;
    logic [NW-1:0]     w_avail;
    logic [NW-1:0]     w_enq_eff;
    logic [NW-1:0]     w_deq_eff;

    // Free space comes from the registered count only, so fetch never sees
    // slots being released by dispatch in the same cycle.
    assign w_free    = CW'(DEPTH) - r_count;
    assign num_fetch = (w_free > CW'(LANES)) ? NW'(LANES) : w_free[NW-1:0];
    assign w_avail   = (r_count > CW'(LANES)) ? NW'(LANES) : r_count[NW-1:0];

    ib_count_clip #(.W(NW)) u_enq_clip (
        .i_req   (enq_count),
        .i_limit (num_fetch),
        .o_min   (w_enq_eff)
    );

    ib_count_clip #(.W(NW)) u_deq_clip (
        .i_req   (deq_count),
        .i_limit (w_avail),
        .o_min   (w_deq_eff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq_eff);
            r_tail  <= r_tail + PW'(w_enq_eff);
            r_count <= r_count + CW'(w_enq_eff) - CW'(w_deq_eff);
            if (enq_count > num_fetch) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Storage is never cleared; only the count decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!flush && (NW'(i) < w_enq_eff)) begin
                r_mem[r_tail + PW'(i)] <= ib_entry_t'(enq_entry_flat[ENTRY_W*(LANES-1-i) +: ENTRY_W]);
            end
        end
    end

    always_comb begin
        deq_entry_flat = '0;
        deq_valid_flat = '0;
        for (int i = 0; i < LANES; i++) begin
            deq_entry_flat[ENTRY_W*(LANES-1-i) +: ENTRY_W] = r_mem[r_head + PW'(i)];
            deq_valid_flat[LANES-1-i] = (CW'(i) < r_count);
        end
    end

    assign count_out    = r_count;
    assign enq_drop_err = r_drop_err;

endmodule

// File: doc/instruction_buffer.md
INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two and at least 4.
REQ-002 Parameter LANES, default 4, enqueue and dequeue width; fixed at 4.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 enq_count  in  3  number of decoded instructions offered this cycle (0..4), lanes 0..enq_count-1.
REQ-006 enq_entry_flat  in  168  four 42-bit entries; lane i SHALL occupy bits [42*(3-i)+41 : 42*(3-i)], so lane 0 is in the MSBs.
REQ-007 Entry layout, MSB to LSB: opcode[4], imm[8], rt[4], ra[4], rb[4], a_dep[1], a_owner[4], b_dep[1], b_owner[4], uses_rb, is_ld_str, is_fxu, is_branch.
REQ-008 num_fetch  out  3  free slots advertised to fetch, equal to min(4, DEPTH-count).
REQ-009 deq_entry_flat  out  168  the oldest four entries, same lane packing as enqueue; lane 0 is the head.
REQ-010 deq_valid_flat  out  4  bit (3-i) set when lane i holds a valid entry.
REQ-011 deq_count  in  3  number of head entries consumed by dispatch this cycle (0..4).
REQ-012 flush  in  1  branch redirect; empties the buffer.
REQ-013 count_out  out  4  current occupancy, 0..DEPTH.

Function
REQ-014 Storage SHALL be a circular array of DEPTH entries, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
REQ-015 num_fetch SHALL be derived from registered count only, with no combinational path from enq_count or deq_count.
REQ-016 On each posedge with enq_eff = min(enq_count, num_fetch), lanes 0..enq_eff-1 SHALL be written to tail, tail+1, ... in order, and tail SHALL advance by enq_eff.
REQ-017 Any enq_count above num_fetch SHALL be clipped; excess lanes SHALL be dropped and a sim-only error SHALL be flagged.
REQ-018 deq lane i SHALL present entry[(head+i) mod DEPTH] combinationally; deq_valid for lane i SHALL equal (i < count).
REQ-019 deq_eff = min(deq_count, count, 4); head SHALL advance by deq_eff.
REQ-020 Next count SHALL equal count + enq_eff - deq_eff; latency from enqueue to visibility on a dequeue lane SHALL be one cycle.
REQ-021 Simultaneous enqueue and dequeue SHALL both take effect. Free space for enqueue SHALL NOT include slots freed in the same cycle, so a full buffer accepts nothing in the cycle it dequeues.
REQ-022 While flush=1, head, tail and count SHALL become 0 at the next edge, and enqueue and dequeue in that cycle SHALL be ignored.
REQ-023 Entry contents are never cleared; validity is determined only by count.
REQ-024 Empty: all deq_valid bits 0 and num_fetch=4. Full: num_fetch=0 and all four deq_valid bits 1.

Reset
REQ-025 On rst_n low, head, tail and count SHALL clear immediately and asynchronously, giving num_fetch=4, deq_valid_flat=0 and count_out=0.
REQ-026 Entry storage SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL discard all entries, including any enqueue in that cycle.

Structure
REQ-028 Entry field widths, the 42-bit entry width, LANES and the opcode constants SHALL live in the shared core package alongside the fetch/decode definitions.
REQ-029 A single sub-module, ib_count_clip, SHALL compute min(request, limit) for both the enqueue and dequeue clipping.
REQ-030 The block SHALL be a single clock domain with no internal clock gating.

Verification
REQ-031 After reset, enqueue 4 entries (opcodes 0,1,2,3) -> next cycle count=4, num_fetch=4, deq_valid=4'b1111, and lane 0 opcode=0.
REQ-032 Enqueue 4 per cycle for 2 cycles with deq_count=0 -> count=8, num_fetch=0; a third enqueue of 4 -> count stays 8 and an error is flagged.
REQ-033 Full buffer with deq_count=3 and enq_count=3 in the same cycle -> count=5, and head advances past the first 3 entries.
REQ-034 Wrap: head=6, tail=6, then 4 enqueues -> entries land in slots 6,7,0,1; after dequeuing 2, lane 0 shows the slot 0 entry.
REQ-035 count=5 with flush=1, enq_count=2 and deq_count=1 -> next cycle count=0, deq_valid=0 and num_fetch=4.
REQ-036 Assert rst_n low mid-stream with count=6 -> outputs clear without waiting for a clock edge; the first enqueue after release appears on lane 0.
